// File: rtl/kirby_key_ctrl.sv
// Frame-synchronous keyboard conditioning for the Kirby motion block:
// frame_clk resync/tick, direction decode, jump edge, hold-to-float and double-tap dash.
module kirby_key_ctrl #(
  parameter logic [7:0]  KEY_LEFT    = 8'h04,
  parameter logic [7:0]  KEY_RIGHT   = 8'h07,
  parameter logic [7:0]  KEY_UP      = 8'h1A,
  parameter logic [7:0]  KEY_DOWN    = 8'h16,
  parameter int unsigned HOLD_FRAMES = 20,
  parameter int unsigned DTAP_FRAMES = 12
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic       frame_tick,
  output logic [7:0] key_frame,
  output logic [1:0] dir_x,
  output logic       facing,
  output logic       duck,
  output logic       jump_req,
  output logic       float,
  output logic       dash
);

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRESS1 = 2'd1;
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam logic [1:0] S_DASH   = 2'd3;

  localparam logic [7:0] HOLD_MAX = 8'(HOLD_FRAMES);
  localparam logic [7:0] DTAP_MAX = 8'(DTAP_FRAMES);

  logic       r_fclk_meta;
  logic       r_fclk_sync;
  logic       r_fclk_prev;
  logic       r_tick;
  logic [7:0] r_key_frame;
  logic [1:0] r_dir;
  logic       r_facing;
  logic       r_duck;
  logic       r_jump;
  logic       r_float;
  logic       r_dash;
  logic [7:0] r_hold_cnt;
  logic [7:0] r_gap_cnt;
  logic [1:0] r_state;
  logic [1:0] r_tdir;

  logic       w_rise;
  logic       w_is_up;
  logic [1:0] w_dir;
  logic [7:0] w_hold_next;
  logic [1:0] w_state_next;
  logic [1:0] w_tdir_next;
  logic [7:0] w_gap_next;

  // Two-flop resync, then a registered edge detect so the tick lands 3 Clk after the rise.
  assign w_rise = r_fclk_sync & ~r_fclk_prev;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_fclk_meta <= 1'b0;
      r_fclk_sync <= 1'b0;
      r_fclk_prev <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_fclk_meta <= frame_clk;
      r_fclk_sync <= r_fclk_meta;
      r_fclk_prev <= r_fclk_sync;
      r_tick      <= w_rise;
    end
  end

  assign w_is_up = (keycode == KEY_UP);

  always_comb begin
    w_dir = DIR_NONE;
    if (keycode == KEY_RIGHT)
      w_dir = DIR_RIGHT;
    else if (keycode == KEY_LEFT)
      w_dir = DIR_LEFT;
  end

  always_comb begin
    w_hold_next = 8'd0;
    if (w_is_up)
      w_hold_next = (r_hold_cnt >= HOLD_MAX) ? HOLD_MAX : r_hold_cnt + 8'd1;
  end

  // Dash detector: tap, bounded release gap, same-direction re-press.
  always_comb begin
    w_state_next = r_state;
    w_tdir_next  = r_tdir;
    w_gap_next   = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_dir != DIR_NONE) begin
          w_state_next = S_PRESS1;
          w_tdir_next  = w_dir;
        end
      end
      S_PRESS1: begin
        if (w_dir == DIR_NONE) begin
          w_state_next = S_GAP;
          w_gap_next   = 8'd1;
        end else if (w_dir != r_tdir) begin
          w_tdir_next  = w_dir;
        end
      end
      S_GAP: begin
        if (w_dir == DIR_NONE) begin
          if (r_gap_cnt < DTAP_MAX)
            w_gap_next   = r_gap_cnt + 8'd1;
          else
            w_state_next = S_IDLE;
        end else if (w_dir == r_tdir) begin
          w_state_next = S_DASH;
        end else begin
          w_state_next = S_PRESS1;
          w_tdir_next  = w_dir;
        end
      end
      S_DASH: begin
        if (w_dir != r_tdir)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Everything below advances only on the frame tick, so outputs are frame-stable.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_key_frame <= 8'd0;
      r_dir       <= DIR_NONE;
      r_facing    <= 1'b0;
      r_duck      <= 1'b0;
      r_jump      <= 1'b0;
      r_float     <= 1'b0;
      r_dash      <= 1'b0;
      r_hold_cnt  <= 8'd0;
      r_gap_cnt   <= 8'd0;
      r_state     <= S_IDLE;
      r_tdir      <= DIR_NONE;
    end else if (r_tick) begin
      r_key_frame <= keycode;
      r_dir       <= w_dir;
      if (w_dir != DIR_NONE)
        r_facing  <= (w_dir == DIR_LEFT);
      r_duck      <= (keycode == KEY_DOWN);
      r_jump      <= w_is_up && (r_key_frame != KEY_UP);
      r_hold_cnt  <= w_hold_next;
      r_float     <= (w_hold_next == HOLD_MAX);
      r_state     <= w_state_next;
      r_tdir      <= w_tdir_next;
      r_gap_cnt   <= w_gap_next;
      r_dash      <= (w_state_next == S_DASH);
    end
  end

  assign frame_tick = r_tick;
  assign key_frame  = r_key_frame;
  assign dir_x      = r_dir;
  assign facing     = r_facing;
  assign duck       = r_duck;
  assign jump_req   = r_jump;
  assign float      = r_float;
  assign dash       = r_dash;

endmodule

// File: tb/tb_kirby_key_ctrl.sv
// Scoreboard bench for kirby_key_ctrl: stimulus pushes hand-computed per-frame
// expectations, a monitor pops and compares after each frame_tick.
module tb_kirby_key_ctrl;

  typedef logic [15:0] exp_t;  // {key_frame, dir_x, facing, duck, jump_req, float, dash}

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       frame_tick;
  logic [7:0] key_frame;
  logic [1:0] dir_x;
  logic       facing;
  logic       duck;
  logic       jump_req;
  logic       float;
  logic       dash;

  exp_t exp_q[$];
  exp_t w_act;
  exp_t last_exp;
  logic chk_next;
  int   n_vec;
  int   n_err;
  int   frame_no;

  kirby_key_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .keycode    (keycode),
    .frame_tick (frame_tick),
    .key_frame  (key_frame),
    .dir_x      (dir_x),
    .facing     (facing),
    .duck       (duck),
    .jump_req   (jump_req),
    .float      (float),
    .dash       (dash)
  );

  assign w_act = {key_frame, dir_x, facing, duck, jump_req, float, dash};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string nm, input exp_t e);
    n_vec++;
    if (w_act !== e) begin
      n_err++;
      $display("FAIL %s frame %0d t=%0t: got key=%h dir=%b face=%b duck=%b jump=%b float=%b dash=%b, want key=%h dir=%b face=%b duck=%b jump=%b float=%b dash=%b",
               nm, frame_no, $time, w_act[15:8], w_act[7:6], w_act[5], w_act[4], w_act[3], w_act[2], w_act[1],
               e[15:8], e[7:6], e[5], e[4], e[3], e[2], e[1]);
    end
  endtask

  // Monitor: reset check, per-frame pop/compare, and hold check on every other cycle.
  initial begin
    last_exp = '0;
    chk_next = 1'b0;
    frame_no = 0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        last_exp = '0;
        chk_next = 1'b0;
        check("reset_outputs", '0);
        n_vec++;
        if (frame_tick !== 1'b0) begin
          n_err++;
          $display("FAIL reset_tick: got %b want 0", frame_tick);
        end
      end else if (chk_next) begin
        chk_next = 1'b0;
        n_vec++;
        if (frame_tick !== 1'b0) begin
          n_err++;
          $display("FAIL tick_width frame %0d: tick still %b one cycle later, want 0", frame_no, frame_tick);
        end
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_tick t=%0t: tick with no expected frame, got 1 want none", $time);
        end else begin
          last_exp = exp_q.pop_front();
          frame_no++;
          check("frame", last_exp);
          $display("frame %0d key=%h dir=%b face=%b duck=%b jump=%b float=%b dash=%b",
                   frame_no, key_frame, dir_x, facing, duck, jump_req, float, dash);
        end
      end else begin
        check("hold", last_exp);
      end
      if (Reset && frame_tick === 1'b1)
        chk_next = 1'b1;
    end
  end

  task automatic frame(input logic [7:0] k, input logic [1:0] d, input logic fc,
                       input logic du, input logic j, input logic fl, input logic ds);
    int lat;
    logic found;
    lat   = 0;
    found = 1'b0;
    @(negedge Clk);
    keycode = k;
    exp_q.push_back({k, d, fc, du, j, fl, ds});
    frame_clk = 1'b1;
    for (int n = 1; n <= 8 && !found; n++) begin
      @(negedge Clk);
      if (frame_tick === 1'b1) begin
        found = 1'b1;
        lat   = n;
      end
    end
    n_vec++;
    if (lat != 3) begin
      n_err++;
      $display("FAIL tick_latency: got %0d Clk after frame_clk rise, want 3", lat);
    end
    // Disturb keycode after the sampling edge; outputs must not follow it.
    @(posedge Clk);
    #1 keycode = k ^ 8'h5A;
    repeat (5) @(posedge Clk);
    frame_clk = 1'b0;
    repeat (8) @(posedge Clk);
  endtask

  task automatic frames(input int cnt, input logic [7:0] k, input logic [1:0] d, input logic fc,
                        input logic du, input logic j, input logic fl, input logic ds);
    for (int i = 0; i < cnt; i++)
      frame(k, d, fc, du, j, fl, ds);
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    #3 Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b1;
    repeat (2) @(posedge Clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    Reset     = 1'b0;
    frame_clk = 1'b0;
    keycode   = 8'h00;
    repeat (4) @(posedge Clk);
    #2 Reset = 1'b1;
    repeat (3) @(posedge Clk);

    // Idle frames: only the tick moves.
    frames(3, 8'h00, 2'b00, 0, 0, 0, 0, 0);

    // Direction decode and facing memory, then a duck frame.
    frames(3, 8'h07, 2'b01, 0, 0, 0, 0, 0);
    frame (8'h04, 2'b10, 1, 0, 0, 0, 0);
    frame (8'h00, 2'b00, 1, 0, 0, 0, 0);
    frame (8'h16, 2'b00, 1, 1, 0, 0, 0);

    // Hold KEY_UP 25 frames: jump on frame 1, float from frame 20.
    frame (8'h1A, 2'b00, 1, 0, 1, 0, 0);
    frames(18, 8'h1A, 2'b00, 1, 0, 0, 0, 0);
    frames(6, 8'h1A, 2'b00, 1, 0, 0, 1, 0);
    frame (8'h00, 2'b00, 1, 0, 0, 0, 0);
    frame (8'h1A, 2'b00, 1, 0, 1, 0, 0);
    frame (8'h00, 2'b00, 1, 0, 0, 0, 0);

    // Right double-tap with a 5-frame gap -> dash while held.
    frames(2, 8'h07, 2'b01, 0, 0, 0, 0, 0);
    frames(5, 8'h00, 2'b00, 0, 0, 0, 0, 0);
    frames(2, 8'h07, 2'b01, 0, 0, 0, 0, 1);
    frame (8'h00, 2'b00, 0, 0, 0, 0, 0);
    // 13-frame gap times out; 12-frame gap is the longest that still dashes.
    frame (8'h07, 2'b01, 0, 0, 0, 0, 0);
    frames(13, 8'h00, 2'b00, 0, 0, 0, 0, 0);
    frame (8'h07, 2'b01, 0, 0, 0, 0, 0);
    frames(12, 8'h00, 2'b00, 0, 0, 0, 0, 0);
    frame (8'h07, 2'b01, 0, 0, 0, 0, 1);
    frame (8'h00, 2'b00, 0, 0, 0, 0, 0);

    // Right, gap 3, left retargets, gap 2, left -> dash left; right breaks it.
    frame (8'h07, 2'b01, 0, 0, 0, 0, 0);
    frames(3, 8'h00, 2'b00, 0, 0, 0, 0, 0);
    frame (8'h04, 2'b10, 1, 0, 0, 0, 0);
    frames(2, 8'h00, 2'b00, 1, 0, 0, 0, 0);
    frames(2, 8'h04, 2'b10, 1, 0, 0, 0, 1);
    frame (8'h07, 2'b01, 0, 0, 0, 0, 0);
    frame (8'h07, 2'b01, 0, 0, 0, 0, 0);

    // Reach DASH right, reset between ticks, restart fresh.
    frame (8'h00, 2'b00, 0, 0, 0, 0, 0);
    frame (8'h07, 2'b01, 0, 0, 0, 0, 1);
    pulse_reset();
    frame (8'h07, 2'b01, 0, 0, 0, 0, 0);
    frame (8'h00, 2'b00, 0, 0, 0, 0, 0);
    frame (8'h07, 2'b01, 0, 0, 0, 0, 1);
    // Previous key is forgotten across reset, so a held KEY_UP jumps again.
    frame (8'h1A, 2'b00, 0, 0, 1, 0, 0);
    pulse_reset();
    frame (8'h1A, 2'b00, 0, 0, 1, 0, 0);
    frame (8'h1A, 2'b00, 0, 0, 0, 0, 0);
    frame (8'h00, 2'b00, 0, 0, 0, 0, 0);

    repeat (5) @(negedge Clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_ticks: got %0d frames unconsumed, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
